alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single combinational 32-bit ALU (op[3:0], a, b -> result, zero) between NUM_REQ independent requesters.
- Round-robin grant, per-requester valid/ready request handshake, registered ALU operands, and a single tagged response channel with valid/ready backpressure.
- Sits between the issuing units (decode/address-gen/branch compare) and the ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal values 2..8.
- DATA_W, 32, operand/result width; must match the ALU.
- ID_W, 2, width of the requester tag; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs on req_valid[i] & req_ready[i].
- req_op  in  4*NUM_REQ  opcode of requester i in bits [4i+3:4i].
- req_a  in  DATA_W*NUM_REQ  operand A of requester i.
- req_b  in  DATA_W*NUM_REQ  operand B of requester i.
- alu_op  out  4  to ALU op.
- alu_a  out  DATA_W  to ALU a.
- alu_b  out  DATA_W  to ALU b.
- alu_result  in  DATA_W  from ALU result.
- alu_zero  in  1  from ALU zero.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester that issued the operation.
- rsp_result  out  DATA_W  captured ALU result.
- rsp_zero  out  1  captured ALU zero flag.
- rsp_err  out  1  illegal-opcode flag (see Optional Feature).

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: state=IDLE; rr_ptr=0; alu_op/alu_a/alu_b=0; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_zero=0; rsp_err=0.
- req_ready is combinational. It is nonzero only in IDLE, and then is a one-hot grant on the first asserted req_valid bit searching from rr_ptr upward, wrapping modulo NUM_REQ. It is all-zero in EXEC and RESP.
- IDLE with a grant g:
  - Register req_op/a/b[g] into alu_op/alu_a/alu_b.
  - Register g into the tag.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Next state EXEC.
- IDLE with no req_valid: remain in IDLE; rr_ptr unchanged.
- EXEC (1 cycle): alu_* are stable. At the end of the cycle, capture alu_result/alu_zero into rsp_result/rsp_zero, rsp_id <= tag, rsp_valid <= 1. Next state RESP.
- RESP: rsp_* are held stable while rsp_valid=1 and rsp_ready=0. On rsp_ready=1: rsp_valid <= 0 and next state IDLE.
- Latency: request accepted at edge N; rsp_valid is high from edge N+2. Best-case throughput is one operation per 3 cycles (rsp_ready tied high).
- alu_op/alu_a/alu_b retain the last issued values outside EXEC. They are not cleared.
- Fairness: a continuously asserting requester is granted at least once every NUM_REQ grants.
- Requester-side rule: once req_valid is asserted, it must hold with stable operands until its transfer. The arbiter does not check this.
- Reset asserted mid-operation (EXEC or RESP): the in-flight operation is dropped with no response, and all registers return to reset values immediately.
- Opcodes and operands are passed to the ALU unmodified, except as defined under Optional Feature.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - In IDLE, if the granted op > 4'b0100 (outside ADD/SUB/AND/OR/XOR), the request is still accepted (rr_ptr advances).
  - The FSM skips EXEC and goes directly to RESP with rsp_err=1, rsp_result=0, rsp_zero=0, rsp_id=g. Latency is 1 edge.
  - alu_* are not updated for that request.
- Undefined: rsp_err is constant 0, and every opcode takes the normal IDLE->EXEC->RESP path.

Test Plan:
- Single op: req_valid=4'b0001, op=0000, a=10, b=5, rsp_ready=1 -> rsp_valid at accept+2 with rsp_result=15, rsp_zero=0, rsp_id=0.
- All four requesters valid, each issuing SUB 7-7, rsp_ready=1 -> grants in order 0,1,2,3; each response has result 0, zero=1, and rsp_id matching the grant.
- Round-robin wrap: req1 and req3 valid continuously after a grant to 3 -> next grants alternate 1,3,1,3.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, with XOR 0xF0F0^0x0FF0 -> rsp_result=0x0000FF00 held stable and req_ready=0 throughout; on release, IDLE follows and the next grant occurs 1 cycle later.
- Reset in EXEC during an AND request -> no rsp_valid, rr_ptr=0, and a subsequent request from req2 completes normally.
- With ALU_ARB_OPCHECK_EN, op=4'b1111 from req1 -> rsp_valid at accept+1, rsp_err=1, result=0, rsp_id=1, alu_op unchanged. Without the macro, the same stimulus yields rsp_err=0 and the ALU's output.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NUM_REQ requesters.
// Grants are round-robin. Each operation runs IDLE -> EXEC -> RESP.
// Operands are registered toward the ALU. The result is returned on one
// tagged response channel that supports valid/ready backpressure.
//
// Optional build macro ALU_ARB_OPCHECK_EN:
//   When defined, a granted opcode above 4'b0100 is accepted but never
//   reaches the ALU. It produces an immediate error response instead.
//   When undefined, rsp_err stays 0 and every opcode goes to the ALU.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [4*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [3:0]                alu_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state, state_next;
  logic [ID_W-1:0]     rr_ptr, rr_next, tag, grant_idx;
  logic                grant_any, op_illegal;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [3:0]          op_arr [NUM_REQ];
  logic [DATA_W-1:0]   a_arr  [NUM_REQ];
  logic [DATA_W-1:0]   b_arr  [NUM_REQ];

  // Split the flat request buses into one entry per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_arr[i] = req_op[4*i +: 4];
    assign a_arr[i]  = req_a[DATA_W*i +: DATA_W];
    assign b_arr[i]  = req_b[DATA_W*i +: DATA_W];
  end

  // Round-robin search: find the first valid requester at or after rr_ptr,
  // wrapping modulo NUM_REQ.
  always_comb begin : grant_search
    int              sum;
    logic [ID_W-1:0] idx;
    // NOTE: give every combinational output a default before any branch.
    // A path that leaves an output unassigned would infer a latch.
    sum       = 0;
    idx       = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_W'(sum);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign grant_oh  = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  assign req_ready = (state == IDLE) ? grant_oh : '0;
  assign rr_next   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef ALU_ARB_OPCHECK_EN
  assign op_illegal = grant_any && (op_arr[grant_idx] > 4'b0100);
`else
  assign op_illegal = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers update with non-blocking assignments, so every
    // flop samples values from before the clock edge.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = op_illegal ? RESP : EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: issue operands, capture the ALU result, hold the response
  // until it is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      tag        <= '0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          rr_ptr <= rr_next;
          if (op_illegal) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant_idx;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b1;
          end else begin
            alu_op <= op_arr[grant_idx];
            alu_a  <= a_arr[grant_idx];
            alu_b  <= b_arr[grant_idx];
            tag    <= grant_idx;
          end
        end
        EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_id     <= tag;
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_err    <= 1'b0;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
